// File: rtl/user_proj_timer_n.sv
// user_proj_timer_n: NCH-channel timer/PWM peripheral on the Caravel Wishbone slave port.
// Each channel has an 8-bit prescaler, an up-counter terminating at LOAD, and one-shot/periodic/PWM output.
module user_proj_timer_n #(
    parameter int          NCH       = 3,
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NCH-1:0]   io_in,
    output logic [NCH-1:0]   io_out,
    output logic [NCH-1:0]   io_oeb,
    output logic [NCH-1:0]   irq
);
    logic           ack_q, ack_d;
    logic [31:0]    dat_q, dat_d;
    logic           go, wr, hit, stat_hit;
    logic [8:0]     off;
    logic [31:0]    wmask, rdata;
    logic [NCH-1:0] ch_hit, pend;
    logic [31:0]    ch_rd [NCH];
    logic           unused_ok;

    assign go        = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wr        = go & wbs_we_i;
    assign hit       = wbs_adr_i[31:9] == BASE_ADDR[31:9];
    assign off       = wbs_adr_i[8:0];
    assign stat_hit  = hit & (off[8:2] == 7'h40);
    assign wmask     = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign unused_ok = &{1'b0, off[1:0]};

    always_comb begin
        rdata = stat_hit ? 32'(pend) : '0;
        for (int i = 0; i < NCH; i++) rdata = ch_hit[i] ? ch_rd[i] : rdata;
    end

    assign ack_d = go;
    assign dat_d = go ? rdata : '0;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [15:0]      ctrl_q, ctrl_d, ctrl_w;
        logic [WIDTH-1:0] load_q, load_d, cmp_q, cmp_d, cnt_q, cnt_d, cnt_nx;
        logic [7:0]       pcnt_q, pcnt_d;
        logic [1:0]       sync_q, sync_d, mode;
        logic             out_q, out_d, pend_q, pend_d;
        logic             wr_ctrl, wr_load, wr_cmp, clr, restart, gated, tick, term, ev;

        assign ch_hit[c] = hit & ~off[8] & (off[7:4] == 4'(c));
        assign wr_ctrl   = wr & ch_hit[c] & (off[3:2] == 2'd0);
        assign wr_load   = wr & ch_hit[c] & (off[3:2] == 2'd1);
        assign wr_cmp    = wr & ch_hit[c] & (off[3:2] == 2'd2);
        assign clr       = wr & stat_hit & wbs_sel_i[0] & wbs_dat_i[c];
        assign ctrl_w    = 16'((32'(ctrl_q) & ~wmask) | (wbs_dat_i & wmask)) & 16'hFF3F;
        assign mode      = ctrl_q[2:1];
        assign restart   = wr_load | (wr_ctrl & ctrl_w[0] & ~ctrl_q[0]);
        assign gated     = ctrl_q[4] & ~sync_q[1];
        assign tick      = ctrl_q[0] & ~gated & (pcnt_q == ctrl_q[15:8]);
        assign term      = tick & (cnt_q == load_q);
        // A LOAD write on the terminal tick restarts the channel and swallows the event.
        assign ev        = term & ~wr_load & (mode != 2'd3);
        assign cnt_nx    = term ? '0 : cnt_q + WIDTH'(1);

        always_comb begin
            ctrl_d = wr_ctrl ? ctrl_w : {ctrl_q[15:1], ctrl_q[0] & ~(ev & (mode == 2'd0))};
            load_d = wr_load ? WIDTH'((32'(load_q) & ~wmask) | (wbs_dat_i & wmask)) : load_q;
            cmp_d  = wr_cmp ? WIDTH'((32'(cmp_q) & ~wmask) | (wbs_dat_i & wmask)) : cmp_q;
            sync_d = {sync_q[0], io_in[c]};
            pcnt_d = (restart | tick) ? '0 : (ctrl_q[0] & ~gated) ? pcnt_q + 8'd1 : pcnt_q;
            cnt_d  = restart ? '0 : tick ? cnt_nx : cnt_q;
            out_d  = restart ? 1'b0 : ~tick ? out_q : (mode == 2'd2) ? (cnt_nx < cmp_q) :
                     (ev & ~mode[1]) ? ~out_q : out_q;
            pend_d = ev | (pend_q & ~clr);
        end

        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
                ctrl_q <= '0;
                load_q <= '0;
                cmp_q  <= '0;
                cnt_q  <= '0;
                pcnt_q <= '0;
                sync_q <= '0;
                out_q  <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                ctrl_q <= ctrl_d;
                load_q <= load_d;
                cmp_q  <= cmp_d;
                cnt_q  <= cnt_d;
                pcnt_q <= pcnt_d;
                sync_q <= sync_d;
                out_q  <= out_d;
                pend_q <= pend_d;
            end
        end

        assign ch_rd[c] = (off[3:2] == 2'd0) ? 32'(ctrl_q) : (off[3:2] == 2'd1) ? 32'(load_q) :
                          (off[3:2] == 2'd2) ? 32'(cmp_q) : 32'(cnt_q);
        assign pend[c]   = pend_q;
        assign io_out[c] = out_q & ctrl_q[5];
        assign io_oeb[c] = ~ctrl_q[5];
        assign irq[c]    = pend_q & ctrl_q[3];
    end
endmodule

// File: tb/tb_user_proj_timer_n.sv
// tb_user_proj_timer_n: directed and randomized checks of the timer against a closed-form model
// of elapsed ticks (ticks = cycles/(PRESCALE+1), events = ticks/(LOAD+1)).
module tb_user_proj_timer_n;
    localparam int          NCH  = 3;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] STAT = BASE + 32'h100;

    logic           clk = 1'b0, rst = 1'b1, stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]     sel = '0;
    logic [31:0]    dat_i = '0, adr = '0, r;
    logic           ack;
    logic [31:0]    dat_o;
    logic [NCH-1:0] io_in = '0, io_out, io_oeb, irq;
    int             n_chk = 0, n_pass = 0, cyc_n = 0, t_wr = 0, rd_n = 0, t0 = 0;

    user_proj_timer_n #(.NCH(NCH), .WIDTH(32), .BASE_ADDR(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called just after a falling edge; the transfer commits on the following rising edge.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] q);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s; rd_n = cyc_n;
        @(negedge clk);
        t_wr = cyc_n;
        check("ack_pulse", 32'(ack), 32'd1);
        q = dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        check("ack_drop", 32'(ack) | dat_o, 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q;
        xfer(1'b1, a, d, 4'hF, q);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] q);
        xfer(1'b0, a, 32'd0, 4'hF, q);
    endtask

    function automatic int m_cnt(int mode, int n, int l, int p);
        int t = n / (p + 1);
        return (mode == 0) ? ((t > l) ? 0 : t) : t % (l + 1);
    endfunction

    function automatic int m_pend(int n, int l, int p);
        return (n / (p + 1) > l) ? 1 : 0;
    endfunction

    function automatic int m_out(int mode, int n, int l, int p, int cmp);
        int t = n / (p + 1);
        if (mode == 2) return (t > 0 && t % (l + 1) < cmp) ? 1 : 0;
        if (mode == 0) return (t > l) ? 1 : 0;
        return (t / (l + 1)) % 2;
    endfunction

    initial begin
        int l, p, m, cm, ch, n, g;
        repeat (3) @(negedge clk);
        check("rst_oeb", 32'(io_oeb), 32'h7);
        check("rst_out_irq", 32'({io_out, irq}), 32'd0);
        check("rst_ack_dat", 32'(ack) | dat_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rd(BASE, r);      check("ctrl0_rst", r, 32'd0);
        rd(BASE + 4, r);  check("load0_rst", r, 32'd0);
        rd(STAT, r);      check("status_rst", r, 32'd0);

        xfer(1'b1, BASE + 4, 32'h1234_5678, 4'hF, r);
        xfer(1'b1, BASE + 4, 32'hAABB_CCDD, 4'b0101, r);
        rd(BASE + 4, r);  check("load_bytesel", r, 32'h12BB_56DD);
        wr(32'h3000_0204, 32'd9);
        rd(BASE + 4, r);  check("other_base", r, 32'h12BB_56DD);
        wr(BASE + 52, 32'd5);
        rd(BASE + 52, r); check("unmapped_ch", r, 32'd0);
        wr(BASE + 16, 32'hFFFF_FFFE);
        rd(BASE + 16, r); check("ctrl_mask", r, 32'hFF3E);
        wr(BASE + 12, 32'd7);
        rd(BASE + 12, r); check("count_ro", r, 32'd0);

        wr(BASE + 4, 32'd4);
        wr(BASE, 32'h2B);
        t0 = t_wr;
        repeat (22) begin
            check("per_out0", 32'(io_out[0]), m_out(1, cyc_n - t0, 4, 0, 0));
            check("per_irq0", 32'(irq[0]), m_pend(cyc_n - t0, 4, 0));
            @(negedge clk);
        end
        wr(BASE, 32'h2A);
        check("irq0_held", 32'(irq[0]), 32'd1);
        wr(STAT, 32'd1);
        check("irq0_w1c", 32'(irq[0]), 32'd0);

        wr(BASE + 20, 32'd9);
        wr(BASE + 16, 32'h329);
        t0 = t_wr;
        repeat (46) begin
            check("os_irq1", 32'(irq[1]), m_pend(cyc_n - t0, 9, 3));
            check("os_out1", 32'(io_out[1]), m_out(0, cyc_n - t0, 9, 3, 0));
            @(negedge clk);
        end
        rd(BASE + 16, r); check("os_en1", r & 32'd1, 32'd0);
        rd(BASE + 28, r); check("os_cnt1", r, 32'd0);

        wr(BASE + 36, 32'd9);
        wr(BASE + 40, 32'd3);
        wr(BASE + 32, 32'h25);
        t0 = t_wr;
        repeat (25) begin
            check("pwm_out2", 32'(io_out[2]), m_out(2, cyc_n - t0, 9, 0, 3));
            @(negedge clk);
        end
        wr(BASE + 40, 32'd0);
        repeat (12) begin
            check("pwm_cmp0", 32'(io_out[2]), 32'd0);
            @(negedge clk);
        end
        wr(BASE + 40, 32'd20);
        repeat (12) begin
            check("pwm_cmp20", 32'(io_out[2]), 32'd1);
            @(negedge clk);
        end

        wr(BASE, 32'd0);
        wr(BASE + 4, 32'd1000);
        wr(BASE, 32'h33);
        repeat (50) @(negedge clk);
        rd(BASE + 12, r); check("gate_hold", r, 32'd0);
        io_in[0] = 1'b1;
        g = cyc_n;
        repeat (2) @(negedge clk);
        rd(BASE + 12, r); check("gate_lat", r, 32'd0);
        repeat (7) @(negedge clk);
        rd(BASE + 12, r); check("gate_resume", r, rd_n - g - 2);

        wr(BASE, 32'd0);
        wr(STAT, 32'd7);
        wr(BASE + 4, 32'd4);
        wr(BASE, 32'h2B);
        t0 = t_wr;
        while (cyc_n - t0 != 9) @(negedge clk);
        wr(STAT, 32'd1);
        check("w1c_set_wins", 32'(irq[0]), 32'd1);
        wr(STAT, 32'd1);
        check("w1c_clear", 32'(irq[0]), 32'd0);
        while ((cyc_n - t0) % 10 != 7) @(negedge clk);
        check("pre_rst_out0", 32'(io_out[0]), m_out(1, cyc_n - t0, 4, 0, 0));
        #2 rst = 1'b1;
        #1;
        check("arst_out", 32'(io_out), 32'd0);
        check("arst_oeb", 32'(io_oeb), 32'h7);
        check("arst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(BASE + 12, r); check("arst_cnt0", r, 32'd0);
        rd(BASE, r);      check("arst_ctrl0", r, 32'd0);

        repeat (8) begin
            ch = int'($urandom_range(0, NCH - 1));
            m  = int'($urandom_range(0, 2));
            l  = int'($urandom_range(0, 12));
            p  = int'($urandom_range(0, 3));
            cm = int'($urandom_range(0, 14));
            n  = int'($urandom_range(5, 90));
            wr(BASE + 32'(16 * ch), 32'd0);
            wr(STAT, 32'd7);
            wr(BASE + 32'(16 * ch + 4), 32'(l));
            wr(BASE + 32'(16 * ch + 8), 32'(cm));
            wr(BASE + 32'(16 * ch), 32'(1 | (m << 1) | 8 | 32 | (p << 8)));
            t0 = t_wr;
            repeat (n) @(negedge clk);
            check("rnd_out", 32'(io_out[ch]), m_out(m, cyc_n - t0, l, p, cm));
            check("rnd_irq", 32'(irq[ch]), m_pend(cyc_n - t0, l, p));
            rd(BASE + 32'(16 * ch + 12), r);
            check("rnd_cnt", r, m_cnt(m, rd_n - t0, l, p));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
